// File: rtl/uart_pkg.sv
// Shared types for the UART frame packer: FSM states, header size and frame info record.
package uart_pkg;

  localparam int HDR_BYTES = 4;

  typedef enum logic [1:0] {
    S_HDR     = 2'd0,
    S_PAYLOAD = 2'd1,
    S_DROP    = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0] task_number;
    logic [31:0] num_valid_bytes;
  } frame_info_t;

endpackage

// File: rtl/word_fifo_fwft.sv
// First-word-fall-through FIFO; a pop in the same cycle frees room for a push even when full.
module word_fifo_fwft #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             do_wr, do_rd;

  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_rd     = rd_en_i && !empty_o;
  assign do_wr     = wr_en_i && (!full_o || do_rd);
  assign count_o   = wr_ptr_q - rd_ptr_q;
  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/uart_frame_packer.sv
// Parses task/length headers from UART bytes and packs the payload into 32-bit stream words.
// Optional inter-byte timeout: define UART_FRAME_PACKER_TIMEOUT_EN.
module uart_frame_packer
  import uart_pkg::*;
#(
  parameter int WORD_FIFO_DEPTH   = 16,
  parameter int MAX_PAYLOAD_BYTES = 4096,
  parameter int TIMEOUT_CYCLES    = 1000000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic [31:0] o_tdata,
  output logic        o_tvalid,
  output logic        o_tlast,
  input  logic        i_tready,
  output logic [31:0] o_task_number,
  output logic [31:0] o_num_valid_bytes_in_last_sample,
  output logic        o_err,
  output logic        o_busy
);

  localparam int AW = $clog2(WORD_FIFO_DEPTH);

  state_e      state_q, state_d;
  logic [23:0] cnt_q, cnt_d, len_q, len_d;
  logic [7:0]  task_q, task_d;
  logic [31:0] pack_q, pack_d;
  frame_info_t pend_q, pend_d, info_q, info_d;
  logic        pend_vld_q, pend_vld_d;
  logic        pushed_q, pushed_d;
  // armed: the pending frame's first word sits first_pos words behind the FIFO head
  logic        armed_q, armed_d;
  logic [AW:0] first_pos_q, first_pos_d;
  logic        err_q, err_d;

  logic [31:0] word;
  logic [23:0] hdr_len;
  logic        hdr_bad, pay_last, push_req, push, pop, fifo_room, tmo_fire;
  logic [32:0] push_data, fifo_rd;
  logic        fifo_full, fifo_empty;
  logic [AW:0] fifo_cnt;

  assign hdr_len   = {i_rx_data, len_q[15:0]};
  assign hdr_bad   = (hdr_len == 24'd0) || (32'(hdr_len) > 32'(MAX_PAYLOAD_BYTES));
  assign pay_last  = (cnt_q == len_q - 24'd1);
  assign pop       = !fifo_empty && i_tready;
  assign fifo_room = !fifo_full || pop;

`ifdef UART_FRAME_PACKER_TIMEOUT_EN
  logic [31:0] tmo_q;
  logic        tmo_active;
  assign tmo_active = (state_q != S_HDR) || (cnt_q[1:0] != 2'd0);
  assign tmo_fire   = tmo_active && !i_rx_valid && (tmo_q == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                                 tmo_q <= '0;
    else if (i_rx_valid || !tmo_active || tmo_fire) tmo_q <= '0;
    else                                          tmo_q <= tmo_q + 32'd1;
  end
`else
  assign tmo_fire = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_HDR;
      cnt_q       <= '0;
      len_q       <= '0;
      task_q      <= '0;
      pack_q      <= '0;
      pend_q      <= '0;
      info_q      <= '0;
      pend_vld_q  <= 1'b0;
      pushed_q    <= 1'b0;
      armed_q     <= 1'b0;
      first_pos_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      task_q      <= task_d;
      pack_q      <= pack_d;
      pend_q      <= pend_d;
      info_q      <= info_d;
      pend_vld_q  <= pend_vld_d;
      pushed_q    <= pushed_d;
      armed_q     <= armed_d;
      first_pos_q <= first_pos_d;
      err_q       <= err_d;
    end
  end

  // Control outputs: word assembly, push request and error pulse.
  always_comb begin
    word = (cnt_q[1:0] == 2'd0) ? 32'd0 : pack_q;
    for (int l = 0; l < 4; l++)
      if (cnt_q[1:0] == 2'(l)) word[8*l +: 8] = i_rx_data;
    push_req  = 1'b0;
    push_data = {pay_last, word};
    err_d     = 1'b0;
    if (tmo_fire) begin
      err_d = 1'b1;
      if (state_q == S_PAYLOAD && cnt_q[1:0] != 2'd0) begin
        push_req  = 1'b1;
        push_data = {1'b1, pack_q};
      end
    end else if (i_rx_valid) begin
      case (state_q)
        S_HDR:     if (cnt_q[1:0] == 2'(HDR_BYTES - 1)) err_d = hdr_bad || pend_vld_q;
        S_PAYLOAD: if (cnt_q[1:0] == 2'd3 || pay_last) begin
                     push_req = 1'b1;
                     err_d    = !fifo_room;
                   end
        default: ;
      endcase
    end
    push = push_req && fifo_room;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    task_d      = task_q;
    pack_d      = pack_q;
    pend_d      = pend_q;
    info_d      = info_q;
    pend_vld_d  = pend_vld_q;
    pushed_d    = pushed_q;
    armed_d     = armed_q;
    first_pos_d = first_pos_q;

    if (pop && armed_q) begin
      if (first_pos_q == '0) begin
        info_d     = pend_q;
        pend_vld_d = 1'b0;
        armed_d    = 1'b0;
      end else begin
        first_pos_d = first_pos_q - 1'b1;
      end
    end
    if (push) begin
      pushed_d = 1'b1;
      if (!pushed_q) begin
        armed_d     = 1'b1;
        first_pos_d = fifo_cnt - {{AW{1'b0}}, pop};
      end
    end

    if (tmo_fire) begin
      state_d = S_HDR;
      cnt_d   = '0;
      if (state_q == S_PAYLOAD && !pushed_q && !push) pend_vld_d = 1'b0;
    end else if (i_rx_valid) begin
      case (state_q)
        S_HDR: begin
          cnt_d = cnt_q + 24'd1;
          case (cnt_q[1:0])
            2'd0: task_d       = i_rx_data;
            2'd1: len_d[7:0]   = i_rx_data;
            2'd2: len_d[15:8]  = i_rx_data;
            default: begin
              cnt_d = '0;
              len_d = hdr_len;
              if (!hdr_bad) begin
                if (pend_vld_q) begin
                  state_d = S_DROP;
                end else begin
                  pend_d.task_number     = {24'd0, task_q};
                  pend_d.num_valid_bytes = (hdr_len[1:0] == 2'd0) ? 32'd4 : {30'd0, hdr_len[1:0]};
                  pend_vld_d = 1'b1;
                  pushed_d   = 1'b0;
                  state_d    = S_PAYLOAD;
                end
              end
            end
          endcase
        end
        S_PAYLOAD: begin
          pack_d = word;
          cnt_d  = cnt_q + 24'd1;
          if (push_req && !fifo_room) begin
            if (!pushed_q) pend_vld_d = 1'b0;
            state_d = pay_last ? S_HDR : S_DROP;
            if (pay_last) cnt_d = '0;
          end else if (pay_last) begin
            state_d = S_HDR;
            cnt_d   = '0;
          end
        end
        S_DROP: begin
          if (pay_last) begin
            state_d = S_HDR;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 24'd1;
          end
        end
        default: state_d = S_HDR;
      endcase
    end
  end

  word_fifo_fwft #(.WIDTH(33), .DEPTH(WORD_FIFO_DEPTH)) u_fifo (
    .clk_i     (i_clk),
    .rst_ni    (i_rst_n),
    .wr_en_i   (push),
    .wr_data_i (push_data),
    .rd_en_i   (i_tready),
    .rd_data_o (fifo_rd),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_cnt)
  );

  assign o_tvalid = !fifo_empty;
  assign o_tdata  = fifo_empty ? 32'd0 : fifo_rd[31:0];
  assign o_tlast  = !fifo_empty && fifo_rd[32];
  assign o_task_number                    = info_q.task_number;
  assign o_num_valid_bytes_in_last_sample = info_q.num_valid_bytes;
  assign o_err  = err_q;
  assign o_busy = (state_q != S_HDR) || (cnt_q[1:0] != 2'd0) || !fifo_empty;

endmodule

// File: tb/tb_uart_frame_packer.sv
// Bench for uart_frame_packer: frame table plus overflow, async reset and timeout sequences.
module tb_uart_frame_packer;

  logic        i_clk = 1'b0, i_rst_n = 1'b0;
  logic [7:0]  i_rx_data = '0;
  logic        i_rx_valid = 1'b0, i_tready = 1'b1;
  logic [31:0] o_tdata, o_task_number, o_num_valid_bytes_in_last_sample;
  logic        o_tvalid, o_tlast, o_err, o_busy;

  uart_frame_packer #(.WORD_FIFO_DEPTH(16), .MAX_PAYLOAD_BYTES(4096), .TIMEOUT_CYCLES(50)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
    .o_tdata(o_tdata), .o_tvalid(o_tvalid), .o_tlast(o_tlast), .i_tready(i_tready),
    .o_task_number(o_task_number),
    .o_num_valid_bytes_in_last_sample(o_num_valid_bytes_in_last_sample),
    .o_err(o_err), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [7:0]  tnum;
    int          len;
    logic [7:0]  seed;
    logic [7:0]  step;
    logic [31:0] exp_task;
    logic [31:0] exp_nvb;
    int          exp_err;
  } vec_t;

  int checks = 0, errors = 0, err_seen = 0, hs_cnt = 0;
  logic [32:0] expq[$];
  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  always @(negedge i_clk) begin
    if (o_err) err_seen++;
    if (i_rst_n && o_tvalid && i_tready) begin
      hs_cnt++;
      if (expq.size() == 0) check("unexpected_word", {31'd0, o_tlast, o_tdata}, 64'h1_0000_0000_0000);
      else check("word", {31'd0, o_tlast, o_tdata}, {31'd0, expq.pop_front()});
    end
  end

  task automatic tick();
    @(posedge i_clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    tick();
    i_rx_valid = 1'b0;
  endtask

  task automatic send_hdr(input logic [7:0] tnum, input int len);
    logic [23:0] l = 24'(len);
    send_byte(tnum);
    send_byte(l[7:0]);
    send_byte(l[15:8]);
    send_byte(l[23:16]);
  endtask

  // Little-endian model; only the first max_words words are expected to reach the output.
  task automatic send_payload(input int len, input logic [7:0] seed, input logic [7:0] step,
                              input int max_words);
    logic [31:0] w = '0;
    logic [7:0]  b;
    int nw = 0;
    for (int i = 0; i < len; i++) begin
      b = seed + 8'(i) * step;
      w[8*(i%4) +: 8] = b;
      if (i % 4 == 3 || i == len - 1) begin
        if (nw < max_words) expq.push_back({(i == len - 1), w});
        nw++;
        w = '0;
      end
      send_byte(b);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    tick(); tick();
    while ((expq.size() != 0 || o_tvalid) && n < 300) begin
      tick();
      n++;
    end
    check("drain_bound", 64'(n < 300), 64'd1);
  endtask

  task automatic run_frame(input vec_t v);
    int e0 = err_seen;
    send_hdr(v.tnum, v.len);
    if (v.exp_err == 0) send_payload(v.len, v.seed, v.step, 1 << 20);
    wait_drain();
    check($sformatf("err_t%0h", v.tnum), 64'(err_seen - e0), 64'(v.exp_err));
    check($sformatf("task_t%0h", v.tnum), 64'(o_task_number), 64'(v.exp_task));
    check($sformatf("nvb_t%0h", v.tnum), 64'(o_num_valid_bytes_in_last_sample), 64'(v.exp_nvb));
    check($sformatf("busy_t%0h", v.tnum), 64'(o_busy), 64'd0);
  endtask

  initial begin
    int e0, h0;
    vec_t v;
    vecs[0] = '{8'h05, 8,    8'h11, 8'h01, 32'h05, 32'd4, 0};
    vecs[1] = '{8'h02, 5,    8'hAA, 8'h11, 32'h02, 32'd1, 0};
    vecs[2] = '{8'h00, 0,    8'h00, 8'h00, 32'h02, 32'd1, 1};
    vecs[3] = '{8'h01, 1,    8'h5A, 8'h01, 32'h01, 32'd1, 0};
    vecs[4] = '{8'hFF, 4097, 8'h00, 8'h00, 32'h01, 32'd1, 1};
    vecs[5] = '{8'h80, 7,    8'h01, 8'h03, 32'h80, 32'd3, 0};
    vecs[6] = '{8'h42, 4096, 8'h00, 8'h01, 32'h42, 32'd4, 0};
    vecs[7] = '{8'h09, 6,    8'hF0, 8'h07, 32'h09, 32'd2, 0};

    tick(); tick();
    check("rst_tvalid", 64'(o_tvalid), 64'd0);
    check("rst_tdata",  64'(o_tdata), 64'd0);
    check("rst_tlast",  64'(o_tlast), 64'd0);
    check("rst_task",   64'(o_task_number), 64'd0);
    check("rst_nvb",    64'(o_num_valid_bytes_in_last_sample), 64'd0);
    check("rst_err",    64'(o_err), 64'd0);
    check("rst_busy",   64'(o_busy), 64'd0);
    i_rst_n = 1'b1;
    tick();

    for (int k = 0; k < 8; k++) run_frame(vecs[k]);

    // Overflow: 24 words into a 16-deep FIFO with the sink stalled.
    i_tready = 1'b0;
    e0 = err_seen;
    send_hdr(8'h07, 96);
    send_payload(96, 8'h30, 8'h01, 16);
    tick(); tick();
    check("ovf_err", 64'(err_seen - e0), 64'd1);
    check("ovf_busy", 64'(o_busy), 64'd1);
    h0 = hs_cnt;
    i_tready = 1'b1;
    wait_drain();
    check("ovf_words", 64'(hs_cnt - h0), 64'd16);
    check("ovf_task", 64'(o_task_number), 64'h07);
    check("ovf_nvb", 64'(o_num_valid_bytes_in_last_sample), 64'd4);
    v = '{8'h0C, 10, 8'h21, 8'h01, 32'h0C, 32'd2, 0};
    run_frame(v);

    // Asynchronous reset in the middle of a payload.
    i_tready = 1'b0;
    send_hdr(8'h03, 8);
    for (int i = 1; i <= 5; i++) send_byte(8'(i));
    check("pre_rst_tvalid", 64'(o_tvalid), 64'd1);
    #2 i_rst_n = 1'b0;
    #1;
    check("arst_tvalid", 64'(o_tvalid), 64'd0);
    check("arst_tdata",  64'(o_tdata), 64'd0);
    check("arst_task",   64'(o_task_number), 64'd0);
    check("arst_nvb",    64'(o_num_valid_bytes_in_last_sample), 64'd0);
    check("arst_busy",   64'(o_busy), 64'd0);
    expq.delete();
    tick();
    i_rst_n  = 1'b1;
    i_tready = 1'b1;
    tick();
    v = '{8'h33, 5, 8'h10, 8'h01, 32'h33, 32'd1, 0};
    run_frame(v);

`ifdef UART_FRAME_PACKER_TIMEOUT_EN
    e0 = err_seen;
    send_hdr(8'h21, 6);
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    expq.push_back({1'b1, 32'h00CCBBAA});
    for (int i = 0; i < 70; i++) tick();
    check("tmo_err", 64'(err_seen - e0), 64'd1);
    check("tmo_words_left", 64'(expq.size()), 64'd0);
    check("tmo_task", 64'(o_task_number), 64'h21);
    check("tmo_nvb", 64'(o_num_valid_bytes_in_last_sample), 64'd2);
`endif

    check("final_queue_empty", 64'(expq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
